// File: rtl/burst_ram_arbiter_pkg.sv
// burst_ram_arbiter_pkg: shared state encoding, requester indices and sizing helper
package burst_ram_arbiter_pkg;
    typedef logic [1:0] state_t;
    localparam state_t IDLE    = 2'd0;
    localparam state_t GRANTED = 2'd1;
    localparam state_t READ    = 2'd2;
    localparam state_t WRITE   = 2'd3;
    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;
    function automatic int cnt_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction
endpackage

// File: rtl/burst_ram_arbiter_if.sv
// burst_ram_arbiter_if: one cache's request/grant handshake and BurstRAM command/data lines
interface burst_ram_arbiter_if #(
    parameter int AW = 4,
    parameter int DW = 64
);
    logic          req;
    logic          gnt;
    logic          cmd;
    logic          cmd_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic [DW/8-1:0] data_mask;
    logic          rd_data_valid;
    logic          busy;
    logic [DW-1:0] rd_data;
    modport master(output req, cmd, cmd_en, addr, wr_data, data_mask,
                   input gnt, rd_data_valid, busy, rd_data);
    modport slave(input req, cmd, cmd_en, addr, wr_data, data_mask,
                  output gnt, rd_data_valid, busy, rd_data);
endinterface

// File: rtl/burst_ram_arbiter_beat_counter.sv
// burst_beat_counter: loadable beat counter flagging the final beat of a burst
module burst_beat_counter
    import burst_ram_arbiter_pkg::*;
#(
    parameter int COUNT = 4,
    localparam int CW = cnt_width(COUNT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          inc,
    input  logic [CW-1:0] load_val,
    output logic          last
);
    logic [CW-1:0] cnt;
    assign last = cnt == CW'(COUNT - 1);
    // load wins over increment; the count holds at the final beat rather than wrapping
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (inc && !last) cnt <= cnt + CW'(1);
endmodule

// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter: round-robin owner of the shared BurstRAM port for the I and D caches
module burst_ram_arbiter
    import burst_ram_arbiter_pkg::*;
#(
    parameter int RAM_DEPTH_BITWIDTH      = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64,
    parameter int RAM_BURST_DATA_COUNT    = 4,
    localparam int CW = cnt_width(RAM_BURST_DATA_COUNT)
) (
    input  logic clk,
    input  logic rst,
    burst_ram_arbiter_if.slave i_bus,
    burst_ram_arbiter_if.slave d_bus,
    output logic br_cmd,
    output logic br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0] br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0] br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0] br_rd_data,
    input  logic br_rd_data_valid,
    input  logic br_busy,
    output logic protocol_err
);
    state_t state, state_d;
    logic [1:0] gnt, gnt_d;
    logic prio, prio_d, err_d, owner, active, pick;
    logic own_req, own_cmd, own_cmd_en, cmd_ok;
    logic cnt_load, cnt_inc, cnt_last;
    logic [CW-1:0] cnt_val;
    logic [RAM_DEPTH_BITWIDTH-1:0] own_addr;
    logic [RAM_BURST_DATA_BITWIDTH-1:0] own_wr_data;
    logic [RAM_BURST_DATA_BITWIDTH/8-1:0] own_mask;

    assign active      = |gnt;
    assign owner       = gnt[REQ_D];
    assign own_req     = owner ? d_bus.req : i_bus.req;
    assign own_cmd     = owner ? d_bus.cmd : i_bus.cmd;
    assign own_cmd_en  = active && (owner ? d_bus.cmd_en : i_bus.cmd_en);
    assign own_addr    = owner ? d_bus.addr : i_bus.addr;
    assign own_wr_data = owner ? d_bus.wr_data : i_bus.wr_data;
    assign own_mask    = owner ? d_bus.data_mask : i_bus.data_mask;
    assign cmd_ok      = state == GRANTED && own_cmd_en && !br_busy;
    assign pick        = (i_bus.req && d_bus.req) ? prio : d_bus.req;

    burst_beat_counter #(.COUNT(RAM_BURST_DATA_COUNT)) u_beats (
        .clk(clk),
        .rst(rst),
        .load(cnt_load),
        .inc(cnt_inc),
        .load_val(cnt_val),
        .last(cnt_last)
    );

    // state, grant, tie-break priority and sticky error registers
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state        <= IDLE;
            gnt          <= '0;
            prio         <= REQ_I;
            protocol_err <= 1'b0;
        end else begin
            state        <= state_d;
            gnt          <= gnt_d;
            prio         <= prio_d;
            protocol_err <= err_d;
        end

    // arbitration, burst sequencing and violation detection; prio favours the requester not served last
    always_comb begin
        state_d  = state;
        gnt_d    = gnt;
        prio_d   = prio;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        cnt_val  = '0;
        err_d    = protocol_err
                 | (i_bus.cmd_en && !gnt[REQ_I])
                 | (d_bus.cmd_en && !gnt[REQ_D])
                 | (own_cmd_en && (br_busy || state != GRANTED))
                 | (br_rd_data_valid && state != READ);
        case (state)
            IDLE: if (i_bus.req || d_bus.req) begin
                state_d = GRANTED;
                gnt_d   = pick ? 2'b10 : 2'b01;
            end
            GRANTED: if (cmd_ok) begin
                cnt_load = 1'b1;
                cnt_val  = own_cmd ? CW'(1) : '0;
                state_d  = !own_cmd ? READ : (RAM_BURST_DATA_COUNT == 1 ? GRANTED : WRITE);
            end else if (!own_req && !own_cmd_en) begin
                state_d = IDLE;
                gnt_d   = '0;
                prio_d  = !owner;
            end
            READ: begin
                cnt_inc = br_rd_data_valid;
                if (br_rd_data_valid && cnt_last) state_d = GRANTED;
            end
            default: begin
                cnt_inc = 1'b1;
                if (cnt_last) state_d = GRANTED;
            end
        endcase
    end

    // owner's command lines to BurstRAM, read-valid steered back to the owner only
    always_comb begin
        br_cmd_en           = cmd_ok;
        br_cmd              = active && own_cmd;
        br_addr             = active ? own_addr : '0;
        br_wr_data          = active ? own_wr_data : '0;
        br_data_mask        = active ? own_mask : '0;
        i_bus.gnt           = gnt[REQ_I];
        d_bus.gnt           = gnt[REQ_D];
        i_bus.rd_data_valid = br_rd_data_valid && state == READ && gnt[REQ_I];
        d_bus.rd_data_valid = br_rd_data_valid && state == READ && gnt[REQ_D];
        i_bus.busy          = br_busy || !gnt[REQ_I] || state != GRANTED;
        d_bus.busy          = br_busy || !gnt[REQ_D] || state != GRANTED;
        i_bus.rd_data       = br_rd_data;
        d_bus.rd_data       = br_rd_data;
    end
endmodule

// File: tb/tb_burst_ram_arbiter.sv
// tb_burst_ram_arbiter: directed checks of grant, burst, fairness and violation behaviour
module tb_burst_ram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    burst_ram_arbiter_if #(.AW(4), .DW(64)) i_bus ();
    burst_ram_arbiter_if #(.AW(4), .DW(64)) d_bus ();

    logic        br_cmd, br_cmd_en, br_rd_data_valid, br_busy, protocol_err;
    logic [3:0]  br_addr;
    logic [63:0] br_wr_data, br_rd_data;
    logic [7:0]  br_data_mask;
    logic [63:0] wd [4];
    int errors = 0;
    int checks = 0;

    burst_ram_arbiter dut (
        .clk(clk),
        .rst(rst),
        .i_bus(i_bus),
        .d_bus(d_bus),
        .br_cmd(br_cmd),
        .br_cmd_en(br_cmd_en),
        .br_addr(br_addr),
        .br_wr_data(br_wr_data),
        .br_data_mask(br_data_mask),
        .br_rd_data(br_rd_data),
        .br_rd_data_valid(br_rd_data_valid),
        .br_busy(br_busy),
        .protocol_err(protocol_err)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        wd = '{64'h11, 64'h22, 64'h33, 64'h44};
        i_bus.req = 1'b1; i_bus.cmd = 1'b0; i_bus.cmd_en = 1'b0;
        i_bus.addr = '0; i_bus.wr_data = '0; i_bus.data_mask = '0;
        d_bus.req = 1'b1; d_bus.cmd = 1'b0; d_bus.cmd_en = 1'b0;
        d_bus.addr = '0; d_bus.wr_data = '0; d_bus.data_mask = '0;
        br_rd_data = '0; br_rd_data_valid = 1'b0; br_busy = 1'b0;
        step(); step(); #1;
        check("rst_i_gnt", i_bus.gnt, 0);
        check("rst_d_gnt", d_bus.gnt, 0);
        check("rst_cmd_en", br_cmd_en, 0);
        check("rst_addr", br_addr, 0);
        check("rst_i_busy", i_bus.busy, 1);
        check("rst_d_busy", d_bus.busy, 1);
        check("rst_err", protocol_err, 0);
        rst = 1'b1;
        step(); #1;
        check("tie_i_gnt", i_bus.gnt, 1);
        check("tie_d_gnt", d_bus.gnt, 0);
        check("tie_i_busy", i_bus.busy, 0);
        check("tie_d_busy", d_bus.busy, 1);
        i_bus.cmd = 1'b1; i_bus.cmd_en = 1'b1; i_bus.addr = 4'd3; i_bus.wr_data = wd[0];
        #1;
        check("wr_cmd_en", br_cmd_en, 1);
        check("wr_cmd", br_cmd, 1);
        check("wr_addr", br_addr, 3);
        check("wr_beat0", br_wr_data, wd[0]);
        check("wr_mask", br_data_mask, 0);
        for (int b = 1; b < 4; b++) begin
            step();
            i_bus.cmd_en = 1'b0; i_bus.wr_data = wd[b];
            #1;
            check("wr_beat", br_wr_data, wd[b]);
            check("wr_busy", i_bus.busy, 1);
            check("wr_no_en", br_cmd_en, 0);
        end
        step(); #1;
        check("wr_done_busy", i_bus.busy, 0);
        i_bus.req = 1'b0;
        #1;
        check("rel_hold_gnt", i_bus.gnt, 1);
        step(); #1;
        check("rel_dead_i", i_bus.gnt, 0);
        check("rel_dead_d", d_bus.gnt, 0);
        step(); #1;
        check("rd_d_gnt", d_bus.gnt, 1);
        d_bus.cmd = 1'b0; d_bus.cmd_en = 1'b1; d_bus.addr = 4'd5;
        #1;
        check("rd_cmd_en", br_cmd_en, 1);
        check("rd_addr", br_addr, 5);
        check("rd_cmd", br_cmd, 0);
        step();
        d_bus.cmd_en = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (b == 2) d_bus.req = 1'b0;
            br_rd_data_valid = 1'b1; br_rd_data = 64'ha0 + 64'(b);
            #1;
            check("rd_d_valid", d_bus.rd_data_valid, 1);
            check("rd_i_valid", i_bus.rd_data_valid, 0);
            check("rd_data", i_bus.rd_data, 64'ha0 + 64'(b));
            check("rd_hold_gnt", d_bus.gnt, 1);
            check("rd_no_en", br_cmd_en, 0);
            step();
        end
        br_rd_data_valid = 1'b0;
        #1;
        check("rd_done_gnt", d_bus.gnt, 1);
        check("rd_done_busy", d_bus.busy, 0);
        step(); #1;
        check("rd_released", d_bus.gnt, 0);
        i_bus.req = 1'b1; d_bus.req = 1'b1;
        step(); #1;
        check("rr1_i", i_bus.gnt, 1);
        check("rr1_d", d_bus.gnt, 0);
        i_bus.req = 1'b0;
        step(); #1;
        check("rr1_dead", {i_bus.gnt, d_bus.gnt}, 0);
        i_bus.req = 1'b1;
        step(); #1;
        check("rr2_d", d_bus.gnt, 1);
        check("rr2_i", i_bus.gnt, 0);
        d_bus.req = 1'b0;
        step(); #1;
        check("rr2_dead", {i_bus.gnt, d_bus.gnt}, 0);
        d_bus.req = 1'b1;
        step(); #1;
        check("rr3_i", i_bus.gnt, 1);
        check("rr3_d", d_bus.gnt, 0);
        check("clean_err", protocol_err, 0);
        d_bus.cmd_en = 1'b1;
        #1;
        check("v1_no_fwd", br_cmd_en, 0);
        step();
        d_bus.cmd_en = 1'b0;
        #1;
        check("v1_err", protocol_err, 1);
        rst = 1'b0;
        #1;
        check("v1_rst_err", protocol_err, 0);
        check("v1_rst_gnt", i_bus.gnt, 0);
        step();
        rst = 1'b1;
        step(); #1;
        check("v2_i_gnt", i_bus.gnt, 1);
        br_busy = 1'b1; i_bus.cmd = 1'b0; i_bus.cmd_en = 1'b1;
        #1;
        check("v2_no_fwd", br_cmd_en, 0);
        check("v2_busy", i_bus.busy, 1);
        step();
        i_bus.cmd_en = 1'b0; br_busy = 1'b0;
        #1;
        check("v2_err", protocol_err, 1);
        check("v2_dropped", i_bus.busy, 0);
        step(); step(); #1;
        check("v2_sticky", protocol_err, 1);
        i_bus.req = 1'b0; d_bus.req = 1'b0; rst = 1'b0;
        #1;
        check("v2_rst_err", protocol_err, 0);
        step();
        rst = 1'b1;
        step();
        br_rd_data_valid = 1'b1;
        #1;
        check("v3_i_valid", i_bus.rd_data_valid, 0);
        check("v3_d_valid", d_bus.rd_data_valid, 0);
        step();
        br_rd_data_valid = 1'b0;
        #1;
        check("v3_err", protocol_err, 1);
        step(); step(); #1;
        check("v3_sticky", protocol_err, 1);
        rst = 1'b0;
        #1;
        check("v3_rst_err", protocol_err, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
